// File: rtl/channel_link_tx.sv
// rtl/channel_link_tx.sv - Channel Link 7:1 transmitter: 28-bit words onto 4 serial lanes plus forwarded clock
module channel_link_tx #(
   parameter logic [27:0] IDLE_WORD = 28'h0000000
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        enable,
   input  logic [27:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [3:0]  data_out,
   output logic        clk_out,
   output logic [2:0]  slot_index,
   output logic        frame_start,
   output logic        underrun
);

   logic [27:0] hold;
   logic [27:0] frame;
   logic [27:0] frame_next;
   logic        hold_full;
   logic        first_boundary;
   logic        boundary;
   logic        accept;
   logic        consume;
   logic [2:0]  slot_next;
   logic [4:0]  slot_bits;

   // Returns {clk_out, lane3, lane2, lane1, lane0} for word w in slot s.
   function automatic logic [4:0] slot_map(input logic [27:0] w, input logic [2:0] s);
      case (s)
         3'd0:    slot_map = {1'b1, w[23], w[26], w[18], w[7]};
         3'd1:    slot_map = {1'b1, w[17], w[25], w[15], w[6]};
         3'd2:    slot_map = {1'b0, w[16], w[24], w[14], w[4]};
         3'd3:    slot_map = {1'b0, w[11], w[22], w[13], w[3]};
         3'd4:    slot_map = {1'b0, w[10], w[21], w[12], w[2]};
         3'd5:    slot_map = {1'b1, w[5],  w[20], w[9],  w[1]};
         default: slot_map = {1'b1, w[27], w[19], w[8],  w[0]};
      endcase
   endfunction

   assign boundary  = (slot_index == 3'd6);
   assign accept    = in_valid && in_ready;
   assign consume   = boundary && enable && hold_full;
   assign slot_next = boundary ? 3'd0 : slot_index + 3'd1;

   always_comb begin
      frame_next = frame;
      if (boundary) begin
         frame_next = consume ? hold : IDLE_WORD;
      end
   end

   // Outputs are registered, so they are computed from the upcoming slot and frame.
   assign slot_bits = slot_map(frame_next, slot_next);

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         slot_index     <= 3'd6;
         frame          <= IDLE_WORD;
         hold           <= '0;
         hold_full      <= 1'b0;
         in_ready       <= 1'b0;
         first_boundary <= 1'b1;
         data_out       <= 4'd0;
         clk_out        <= 1'b0;
         frame_start    <= 1'b0;
         underrun       <= 1'b0;
      end else begin
         slot_index     <= slot_next;
         frame          <= frame_next;
         first_boundary <= 1'b0;
         if (accept) begin
            hold      <= in_data;
            hold_full <= 1'b1;
            in_ready  <= 1'b0;
         end else begin
            if (consume) begin
               hold_full <= 1'b0;
            end
            in_ready <= !(hold_full && !consume);
         end
         {clk_out, data_out} <= slot_bits;
         frame_start         <= (slot_next == 3'd0);
         // The very first boundary after reset never reports an underrun.
         underrun            <= boundary && enable && !hold_full && !first_boundary;
      end
   end

endmodule

// File: tb/tb_channel_link_tx.sv
// tb/tb_channel_link_tx.sv - self-checking bench for channel_link_tx with frame deserializing scoreboard
module tb_channel_link_tx;

   logic        clk_in = 1'b0;
   logic        reset;
   logic        enable;
   logic [27:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  data_out;
   logic        clk_out;
   logic [2:0]  slot_index;
   logic        frame_start;
   logic        underrun;

   channel_link_tx #(.IDLE_WORD(28'h0000000)) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .enable      (enable),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .data_out    (data_out),
      .clk_out     (clk_out),
      .slot_index  (slot_index),
      .frame_start (frame_start),
      .underrun    (underrun)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [27:0] word;
      logic [6:0]  lane0;
   } vec_t;

   vec_t   vecs [5];
   vec_t   sb_q [$];
   vec_t   mon_e;
   int     map_bit [4][7];
   logic [6:0] clk_pat = 7'b1100011;
   logic   grid [4][7];
   logic   have_start = 1'b0;
   logic [2:0]  exp_slot;
   logic [27:0] mon_w;
   logic [6:0]  mon_l0;
   int     n_checks = 0;
   int     n_fail = 0;
   int     ur_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] lane0_of(input logic [27:0] w);
      logic [6:0] r;
      for (int s = 0; s < 7; s++) r[6-s] = w[map_bit[0][s]];
      return r;
   endfunction

   task automatic tick();
      @(negedge clk_in);
      #1;
   endtask

   task automatic wait_slot(input logic [2:0] k);
      int n = 0;
      while (slot_index != k && n < 20) begin
         tick();
         n++;
      end
      check("wait_slot_timeout", 32'(n < 20), 32'd1);
   endtask

   task automatic send(input logic [27:0] w, input logic [6:0] l0, input bit push);
      int n = 0;
      in_data  = w;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      check("send_timeout", 32'(n < 100), 32'd1);
      if (push) sb_q.push_back('{w, l0});
      tick();
      in_valid = 1'b0;
   endtask

   always @(posedge clk_in or negedge reset) begin
      if (!reset) exp_slot <= 3'd6;
      else        exp_slot <= (exp_slot == 3'd6) ? 3'd0 : exp_slot + 3'd1;
   end

   // Receiver-side monitor: rebuilds each frame from the lanes using the bench bit map.
   always @(negedge clk_in) begin
      if (!reset) begin
         have_start = 1'b0;
      end else begin
         check("slot_index", 32'(slot_index), 32'(exp_slot));
         check("clk_out", 32'(clk_out), 32'(clk_pat[6-int'(exp_slot)]));
         check("frame_start", 32'(frame_start), 32'(exp_slot == 3'd0));
         if (underrun) begin
            ur_cnt++;
            check("underrun_slot", 32'(exp_slot), 32'd0);
         end
         for (int l = 0; l < 4; l++) grid[l][int'(exp_slot)] = data_out[l];
         if (exp_slot == 3'd0) have_start = 1'b1;
         if (exp_slot == 3'd6 && have_start) begin
            for (int l = 0; l < 4; l++)
               for (int s = 0; s < 7; s++) mon_w[map_bit[l][s]] = grid[l][s];
            for (int s = 0; s < 7; s++) mon_l0[6-s] = grid[0][s];
            if (mon_w != 28'd0) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_frame", 32'(mon_w), 32'd0);
               end else begin
                  mon_e = sb_q.pop_front();
                  check("frame_word", 32'(mon_w), 32'(mon_e.word));
                  check("lane0_serial", 32'(mon_l0), 32'(mon_e.lane0));
               end
            end
         end
      end
   end

   initial begin
      int ur0;
      int cnt;
      logic [27:0] w;

      map_bit = '{'{7, 6, 4, 3, 2, 1, 0},
                  '{18, 15, 14, 13, 12, 9, 8},
                  '{26, 25, 24, 22, 21, 20, 19},
                  '{23, 17, 16, 11, 10, 5, 27}};
      vecs[0] = '{28'h0000001, 7'b0000001};
      vecs[1] = '{28'hFFFFFFF, 7'b1111111};
      vecs[2] = '{28'h5A5A5A5, 7'b1000101};
      vecs[3] = '{28'h0123456, 7'b0110110};
      vecs[4] = '{28'h8C3E71B, 7'b0011011};

      reset = 1'b0; enable = 1'b1; in_valid = 1'b0; in_data = 28'd0;
      repeat (3) tick();
      check("rst_slot", 32'(slot_index), 32'd6);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_frame_start", 32'(frame_start), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);

      reset = 1'b1;
      tick();
      check("first_slot", 32'(slot_index), 32'd0);
      check("first_clk_out", 32'(clk_out), 32'd1);
      check("first_data_out", 32'(data_out), 32'd0);
      check("first_underrun", 32'(underrun), 32'd0);
      check("first_in_ready", 32'(in_ready), 32'd1);
      ur0 = ur_cnt;
      repeat (21) tick();
      check("idle_underruns", 32'(ur_cnt - ur0), 32'd3);

      // Single word accepted mid-frame; in_ready low until the boundary.
      wait_slot(3'd2);
      send(vecs[0].word, vecs[0].lane0, 1'b1);
      cnt = 0;
      while (!in_ready && cnt < 20) begin
         cnt++;
         tick();
      end
      check("ready_low_cycles", 32'(cnt), 32'd4);
      check("loaded_frame_start", 32'(frame_start), 32'd1);
      check("loaded_no_underrun", 32'(underrun), 32'd0);
      repeat (10) tick();

      // Back-to-back words from the table.
      ur0 = ur_cnt;
      for (int i = 1; i < 4; i++) send(vecs[i].word, vecs[i].lane0, 1'b1);
      check("b2b_no_underrun", 32'(ur_cnt - ur0), 32'd0);
      repeat (20) tick();

      // Walking one over every bit position.
      for (int i = 0; i < 28; i++) begin
         w = 28'd1 << i;
         send(w, lane0_of(w), 1'b1);
      end
      repeat (20) tick();
      check("walk_drained", 32'(sb_q.size()), 32'd0);

      // Disabled link holds the word and sends idle frames.
      enable = 1'b0;
      tick();
      send(vecs[4].word, vecs[4].lane0, 1'b1);
      ur0 = ur_cnt;
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (in_ready) cnt++;
         tick();
      end
      check("disabled_ready_high", 32'(cnt), 32'd0);
      check("disabled_no_underrun", 32'(ur_cnt - ur0), 32'd0);
      check("disabled_held", 32'(sb_q.size()), 32'd1);
      enable = 1'b1;
      repeat (20) tick();
      check("enable_sent", 32'(sb_q.size()), 32'd0);

      // Asynchronous reset mid-frame discards both the frame and the held word.
      send(28'hFFFFFFF, 7'b1111111, 1'b0);
      send(28'h0123456, 7'b0110110, 1'b0);
      wait_slot(3'd3);
      check("pre_rst_data", 32'(data_out), 32'hF);
      check("pre_rst_held", 32'(in_ready), 32'd0);
      #1 reset = 1'b0;
      #1;
      check("async_data_out", 32'(data_out), 32'd0);
      check("async_clk_out", 32'(clk_out), 32'd0);
      check("async_slot", 32'(slot_index), 32'd6);
      check("async_in_ready", 32'(in_ready), 32'd0);
      check("async_underrun", 32'(underrun), 32'd0);
      check("async_frame_start", 32'(frame_start), 32'd0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check("rerst_in_ready", 32'(in_ready), 32'd1);
      check("rerst_slot", 32'(slot_index), 32'd0);
      check("rerst_underrun", 32'(underrun), 32'd0);
      repeat (21) tick();
      check("final_queue_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/channel_link_tx.md
Name: channel_link_tx

Overview:
- Camera Link / Channel Link transmitter serializer.
- Accepts 28-bit parallel words through a valid/ready handshake.
- Serializes each word 7:1 onto 4 data lanes, plus a forwarded pixel-clock lane (pattern 1100011), all clocked by the 7x bit clock.
- Bit-to-slot mapping is the exact inverse of the team's channel_link receiver, so a tx→rx loopback reproduces the input word.

Parameters:
- IDLE_WORD, 28'h0000000, word sent on any frame boundary where no data is loaded (underrun or disabled).

Ports:
- clk_in  input  1  7x serial bit clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- enable  input  1  sampled only at the frame boundary; 0 forces IDLE_WORD and holds off consumption.
- in_data  input  28  parallel word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  holding register empty; transfer on in_valid && in_ready at posedge.
- data_out  output  4  serial lanes 0..3.
- clk_out  output  1  forwarded clock lane.
- slot_index  output  3  current bit slot 0..6.
- frame_start  output  1  high during the slot-0 cycle.
- underrun  output  1  one-cycle pulse; boundary hit with enable=1 and holding register empty.

Behaviour:
- Slot counter
  - slot_index increments each clk_in edge and wraps 6→0.
  - A frame is 7 cycles, slots 0..6, transmitted in slot order 0 first.
- Holding register (1 deep)
  - Loaded on handshake.
  - in_ready is registered: in_ready = !hold_full, updated the same edge hold_full changes.
  - No accept is possible while full.
- Frame boundary (the edge leaving slot 6)
  - If enable=1 and hold_full: frame register <= hold, hold_full <= 0.
  - If enable=1 and hold empty: frame <= IDLE_WORD and underrun pulses during the following slot-0 cycle.
  - If enable=0: frame <= IDLE_WORD, hold retained, no underrun.
  - A handshake completing on the boundary edge with hold previously empty fills hold only. It is not bypassed into this frame; it is sent next frame.
- Registered outputs: during the cycle where slot_index=k, with word w the current frame:
  - lane0, slots 0..6 = w[7], w[6], w[4], w[3], w[2], w[1], w[0]
  - lane1, slots 0..6 = w[18], w[15], w[14], w[13], w[12], w[9], w[8]
  - lane2, slots 0..6 = w[26], w[25], w[24], w[22], w[21], w[20], w[19]
  - lane3, slots 0..6 = w[23], w[17], w[16], w[11], w[10], w[5], w[27]
  - clk_out, slots 0..6 = 1, 1, 0, 0, 0, 1, 1
  - frame_start = (k==0).
- Latency: a word accepted at edge E (hold previously empty, frame in progress) appears in the frame starting at the next boundary. Its slot-0 bits are on data_out in the cycle after that boundary edge.
- Reset (asynchronous assert, any time including mid-frame)
  - slot_index=6, frame=IDLE_WORD, hold empty, in_ready=0.
  - data_out=0, clk_out=0, frame_start=0, underrun=0.
  - The first edge after deassertion is a boundary. in_ready goes to 1 on that edge, so no word can be loaded there.
  - Underrun is suppressed on this first post-reset boundary only.
  - The in-flight frame and held word are discarded; no partial frame is resumed.
- Mapping is fixed; no lane or slot reordering options.

Test Plan:
- Reset release with in_valid=0, IDLE_WORD=0 → first cycle slot_index=0, clk_out=1, data_out=0, underrun=0. clk_out sequence then repeats 1100011 per 7 cycles; underrun pulses at every later slot 0.
- Single word 28'h0000001 accepted mid-frame → next frame lane0 is high only in slot 6, all other lanes 0. in_ready 0 for exactly the cycles between the accept and the boundary.
- Back-to-back words 28'hFFFFFFF, 28'h5A5A5A5, 28'h0123456 with in_valid held high → one accept per frame, no underrun. Loopback into the channel_link receiver reproduces each word in order.
- Walking-one over all 28 bits → each bit appears on exactly the lane/slot listed above, matching the receiver bit map.
- enable=0 across two boundaries with a word held → IDLE_WORD frames sent, no underrun, in_ready stays 0. After enable=1 the held word goes in the next frame.
- reset asserted at slot 3 with a word held → outputs 0 immediately (asynchronous). After release, frame=IDLE_WORD, held word lost, in_ready=1 after the first edge.
